// File: rtl/stack_seq.sv
// stack_seq
//   Stack push/pop sequencer. Owns the stack pointer and splits one 16-bit
//   PUSH or POP into two 8-bit transfers on the CPU data bus.
//
// Ports
//   clk, rst           system clock, synchronous active-high reset
//   start, op          request strobe and operation (0 = PUSH, 1 = POP)
//   push_data          register pair to push, captured with start
//   sp_wr, sp_we       stack pointer load value / enable (IDLE only)
//   sp                 current stack pointer
//   busy, done         operation in progress / one-cycle completion pulse
//   pop_data, pop_we   popped pair and its register write strobe
//   mem_addr, mem_wdata, mem_wr, mem_req   bus request side
//   mem_rdata, mem_ack                     bus response side
module stack_seq #(
  parameter logic [15:0] SP_RESET = 16'hFFFE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        op,
  input  logic [15:0] push_data,
  input  logic [15:0] sp_wr,
  input  logic        sp_we,
  output logic [15:0] sp,
  output logic        busy,
  output logic        done,
  output logic [15:0] pop_data,
  output logic        pop_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_wr,
  output logic        mem_req,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {
    IDLE,
    BYTE0,
    BYTE1
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] sp_q, sp_d;
  logic        op_q, op_d;
  logic [7:0]  hold_lo_q, hold_lo_d;
  logic [15:0] pop_data_q, pop_data_d;
  logic        done_q, done_d;
  logic        pop_we_q, pop_we_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [7:0]  mem_wdata_q, mem_wdata_d;
  logic        mem_wr_q, mem_wr_d;
  logic        mem_req_q, mem_req_d;
  logic [15:0] sp_base;

  // Next-state and registered-output computation. Bus outputs are prepared
  // one cycle ahead so every output comes straight from a flop. Only the low
  // push byte needs holding: the high byte goes onto the bus at acceptance.
  always_comb begin
    state_d     = state_q;
    sp_d        = sp_q;
    op_d        = op_q;
    hold_lo_d   = hold_lo_q;
    pop_data_d  = pop_data_q;
    done_d      = 1'b0;
    pop_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wr_d    = mem_wr_q;
    mem_req_d   = mem_req_q;
    sp_base     = sp_q;

    case (state_q)
      IDLE: begin
        // A load issued together with start is visible to that operation.
        sp_base = sp_we ? sp_wr : sp_q;
        sp_d    = sp_base;
        if (start) begin
          state_d     = BYTE0;
          op_d        = op;
          hold_lo_d   = push_data[7:0];
          mem_req_d   = 1'b1;
          mem_wr_d    = ~op;
          mem_addr_d  = op ? sp_base : sp_base - 16'd1;
          mem_wdata_d = op ? 8'h00 : push_data[15:8];
        end
      end

      BYTE0: begin
        if (mem_ack) begin
          state_d = BYTE1;
          if (op_q) begin
            sp_d             = sp_q + 16'd1;
            pop_data_d[7:0]  = mem_rdata;
            mem_addr_d       = sp_q + 16'd1;
          end else begin
            sp_d        = sp_q - 16'd1;
            mem_addr_d  = sp_q - 16'd2;
            mem_wdata_d = hold_lo_q;
          end
        end
      end

      BYTE1: begin
        if (mem_ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          mem_wr_d  = 1'b0;
          done_d    = 1'b1;
          pop_we_d  = op_q;
          if (op_q) begin
            sp_d              = sp_q + 16'd1;
            pop_data_d[15:8]  = mem_rdata;
          end else begin
            sp_d = sp_q - 16'd1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset aborts any transfer without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sp_q        <= SP_RESET;
      op_q        <= 1'b0;
      hold_lo_q   <= 8'h00;
      pop_data_q  <= 16'h0000;
      done_q      <= 1'b0;
      pop_we_q    <= 1'b0;
      mem_addr_q  <= 16'h0000;
      mem_wdata_q <= 8'h00;
      mem_wr_q    <= 1'b0;
      mem_req_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sp_q        <= sp_d;
      op_q        <= op_d;
      hold_lo_q   <= hold_lo_d;
      pop_data_q  <= pop_data_d;
      done_q      <= done_d;
      pop_we_q    <= pop_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wr_q    <= mem_wr_d;
      mem_req_q   <= mem_req_d;
    end
  end

  assign sp        = sp_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign pop_data  = pop_data_q;
  assign pop_we    = pop_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wr    = mem_wr_q;
  assign mem_req   = mem_req_q;

endmodule

// File: tb/tb_stack_seq.sv
// tb_stack_seq
//   Self-checking bench for stack_seq. A byte-array memory and a stack
//   pointer/popped-pair model predict every bus transfer and result.
module tb_stack_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        op;
  logic [15:0] push_data;
  logic [15:0] sp_wr;
  logic        sp_we;
  logic [15:0] sp;
  logic        busy;
  logic        done;
  logic [15:0] pop_data;
  logic        pop_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_wr;
  logic        mem_req;
  logic [7:0]  mem_rdata;
  logic        mem_ack;

  int total  = 0;
  int passed = 0;

  logic [15:0] model_sp;
  logic [15:0] model_pop;
  logic [7:0]  ref_mem [0:65535];

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  stack_seq dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .push_data (push_data),
    .sp_wr     (sp_wr),
    .sp_we     (sp_we),
    .sp        (sp),
    .busy      (busy),
    .done      (done),
    .pop_data  (pop_data),
    .pop_we    (pop_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wr    (mem_wr),
    .mem_req   (mem_req),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    total++;
    assert (observed === expected) passed++;
    else $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
  endtask

  // One complete operation driven from a negedge, with a configurable number
  // of wait cycles before each ack and optional disturbance while busy.
  task automatic applyStimulus(input logic op_i, input logic [15:0] data_i,
                               input logic load_i, input logic [15:0] load_v,
                               input int waits, input logic disturb);
    logic [15:0] base;
    logic [15:0] exp_addr [2];
    logic [7:0]  exp_wd [2];
    int acks;
    int wcnt;
    int cyc;
    base = load_i ? load_v : model_sp;
    if (!op_i) begin
      exp_addr[0] = base - 16'd1;
      exp_addr[1] = base - 16'd2;
      exp_wd[0]   = data_i[15:8];
      exp_wd[1]   = data_i[7:0];
    end else begin
      exp_addr[0] = base;
      exp_addr[1] = base + 16'd1;
      exp_wd[0]   = 8'h00;
      exp_wd[1]   = 8'h00;
    end
    start = 1'b1; op = op_i; push_data = data_i; sp_we = load_i; sp_wr = load_v;
    @(negedge clk);
    start = 1'b0; sp_we = 1'b0;
    cyc = 1; acks = 0; wcnt = 0;
    while (acks < 2 && cyc < 100) begin
      checkOutput("busy", 16'(busy), 16'd1);
      checkOutput("mem_req", 16'(mem_req), 16'd1);
      checkOutput("done_early", 16'(done), 16'd0);
      checkOutput("mem_addr", mem_addr, exp_addr[acks]);
      checkOutput("mem_wr", 16'(mem_wr), 16'(!op_i));
      if (!op_i) checkOutput("mem_wdata", 16'(mem_wdata), 16'(exp_wd[acks]));
      checkOutput("sp_mid", sp, op_i ? base + 16'(acks) : base - 16'(acks));
      if (disturb && acks == 0 && wcnt == 0) begin
        start = 1'b1; op = ~op_i; sp_we = 1'b1; sp_wr = 16'h1234;
      end
      if (wcnt == waits) begin
        mem_ack = 1'b1;
        if (op_i) begin
          mem_rdata = ref_mem[exp_addr[acks]];
          if (acks == 0) model_pop[7:0] = mem_rdata;
          else model_pop[15:8] = mem_rdata;
        end else begin
          ref_mem[exp_addr[acks]] = exp_wd[acks];
        end
        acks++;
        wcnt = 0;
      end else begin
        mem_rdata = 8'($urandom);
        wcnt++;
      end
      @(negedge clk);
      mem_ack = 1'b0; start = 1'b0; sp_we = 1'b0;
      cyc++;
    end
    checkOutput("ack_count", 16'(acks), 16'd2);
    model_sp = op_i ? base + 16'd2 : base - 16'd2;
    checkOutput("latency", 16'(cyc), 16'(3 + 2 * waits));
    checkOutput("done", 16'(done), 16'd1);
    checkOutput("pop_we", 16'(pop_we), 16'(op_i));
    checkOutput("busy_done", 16'(busy), 16'd0);
    checkOutput("req_done", 16'(mem_req), 16'd0);
    checkOutput("sp_final", sp, model_sp);
    checkOutput("pop_data", pop_data, model_pop);
    @(negedge clk);
    checkOutput("done_pulse", 16'(done), 16'd0);
    checkOutput("pop_we_pulse", 16'(pop_we), 16'd0);
    checkOutput("pop_hold", pop_data, model_pop);
    checkOutput("sp_hold", sp, model_sp);
  endtask

  // Directed spec scenarios followed by randomized operations.
  initial begin
    rst = 1'b1; start = 1'b0; op = 1'b0; push_data = 16'h0000;
    sp_wr = 16'h0000; sp_we = 1'b0; mem_rdata = 8'h00; mem_ack = 1'b0;
    for (int i = 0; i < 65536; i++) ref_mem[i] = 8'($urandom);
    ref_mem[16'hC000] = 8'hCD;
    ref_mem[16'hC001] = 8'hAB;
    repeat (2) @(negedge clk);
    checkOutput("rst_sp", sp, 16'hFFFE);
    checkOutput("rst_busy", 16'(busy), 16'd0);
    checkOutput("rst_done", 16'(done), 16'd0);
    checkOutput("rst_req", 16'(mem_req), 16'd0);
    checkOutput("rst_wr", 16'(mem_wr), 16'd0);
    checkOutput("rst_addr", mem_addr, 16'h0000);
    checkOutput("rst_wdata", 16'(mem_wdata), 16'd0);
    checkOutput("rst_pop", pop_data, 16'h0000);
    checkOutput("rst_pop_we", 16'(pop_we), 16'd0);
    rst = 1'b0;
    model_sp = 16'hFFFE;
    model_pop = 16'h0000;

    $display("[TB] push 0x1234 from reset sp");
    applyStimulus(1'b0, 16'h1234, 1'b0, 16'h0000, 0, 1'b0);
    checkOutput("push_sp", sp, 16'hFFFC);

    $display("[TB] pop from 0xC000 with two wait cycles");
    applyStimulus(1'b1, 16'h0000, 1'b1, 16'hC000, 2, 1'b0);
    checkOutput("pop_abcd", pop_data, 16'hABCD);
    checkOutput("pop_sp", sp, 16'hC002);

    $display("[TB] wrap-around push and pop");
    applyStimulus(1'b0, 16'hBEEF, 1'b1, 16'h0000, 0, 1'b0);
    checkOutput("wrap_push_sp", sp, 16'hFFFE);
    applyStimulus(1'b1, 16'h0000, 1'b1, 16'hFFFF, 1, 1'b0);
    checkOutput("wrap_pop_sp", sp, 16'h0001);

    $display("[TB] control inputs while busy");
    applyStimulus(1'b0, 16'h5A5A, 1'b1, 16'h8000, 2, 1'b1);
    checkOutput("busy_ctl_sp", sp, 16'h7FFE);

    $display("[TB] stray ack while idle");
    mem_ack = 1'b1; mem_rdata = 8'h77;
    @(negedge clk);
    mem_ack = 1'b0;
    checkOutput("stray_sp", sp, model_sp);
    checkOutput("stray_busy", 16'(busy), 16'd0);
    checkOutput("stray_req", 16'(mem_req), 16'd0);
    checkOutput("stray_done", 16'(done), 16'd0);
    checkOutput("stray_pop", pop_data, model_pop);

    $display("[TB] reset during push after first ack");
    start = 1'b1; op = 1'b0; push_data = 16'h1111; sp_we = 1'b1; sp_wr = 16'h4000;
    @(negedge clk);
    start = 1'b0; sp_we = 1'b0; mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    checkOutput("abort_sp_mid", sp, 16'h3FFF);
    ref_mem[16'h3FFF] = 8'h11;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_sp = 16'hFFFE;
    model_pop = 16'h0000;
    checkOutput("abort_req", 16'(mem_req), 16'd0);
    checkOutput("abort_sp", sp, 16'hFFFE);
    checkOutput("abort_busy", 16'(busy), 16'd0);
    checkOutput("abort_done", 16'(done), 16'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("abort_no_done", 16'(done), 16'd0);
    end
    applyStimulus(1'b1, 16'h0000, 1'b0, 16'h0000, 1, 1'b0);
    checkOutput("abort_pop", pop_data, 16'hBEEF);

    $display("[TB] randomized operations");
    for (int n = 0; n < 16; n++) begin
      applyStimulus(1'($urandom_range(0, 1)), 16'($urandom),
                    ($urandom_range(0, 3) == 0), 16'($urandom),
                    int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
